// File: rtl/dram_arbiter.sv
// Round-robin arbiter that serializes NUM_CORES core ports onto the single shared
// DRAM. Write and read sequences are driven entirely from registered state.
module dram_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int AW        = 16,
  parameter int DW        = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CORES-1:0]    core_req,
  input  logic [NUM_CORES-1:0]    core_we,
  input  logic [NUM_CORES*AW-1:0] core_addr,
  input  logic [NUM_CORES*DW-1:0] core_wdata,
  output logic [NUM_CORES-1:0]    core_ack,
  output logic [DW-1:0]           core_rdata,
  output logic                    busy,
  output logic                    mem_write_en,
  output logic                    mem_addr_write_en,
  output logic [AW-1:0]           mem_addr,
  output logic [DW-1:0]           mem_data_in,
  input  logic [DW-1:0]           mem_data_out
);
  localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [2:0] {IDLE, WA1, WA2, WR, RD, RDW, RESP} state_t;

  state_t                state_q;
  logic [IW-1:0]         rr_q, lat_id_q;
  logic [AW-1:0]         lat_addr_q;
  logic [DW-1:0]         lat_wdata_q;
  logic [NUM_CORES-1:0]  ack_q;
  logic [DW-1:0]         rdata_q;
  logic                  mem_we_q, mem_awe_q;
  logic [AW-1:0]         mem_addr_q;
  logic [DW-1:0]         mem_din_q;

  logic                  win_found;
  logic [IW-1:0]         win_id;
  logic [AW-1:0]         win_addr;
  logic [DW-1:0]         win_wdata;

  // Search starts one past the last winner so every requester is reached.
  always_comb begin
    int j;
    win_found = 1'b0;
    win_id    = rr_q;
    j         = 0;
    for (int k = 1; k <= NUM_CORES; k++) begin
      j = (int'(rr_q) + k) % NUM_CORES;
      if (!win_found && core_req[j]) begin
        win_found = 1'b1;
        win_id    = IW'(j);
      end
    end
    win_addr  = core_addr[win_id*AW +: AW];
    win_wdata = core_wdata[win_id*DW +: DW];
  end

  // Mem outputs are registered for the state being entered, so each output
  // lines up with the state it belongs to without any input-to-output path.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_q        <= IW'(NUM_CORES-1);
      lat_id_q    <= '0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      ack_q       <= '0;
      rdata_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_awe_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
    end else begin
      ack_q      <= '0;
      mem_we_q   <= 1'b0;
      mem_awe_q  <= 1'b0;
      mem_din_q  <= '0;
      mem_addr_q <= lat_addr_q;
      case (state_q)
        IDLE: begin
          mem_addr_q <= '0;
          if (win_found) begin
            lat_id_q    <= win_id;
            lat_addr_q  <= win_addr;
            lat_wdata_q <= win_wdata;
            rr_q        <= win_id;
            mem_addr_q  <= win_addr;
            mem_din_q   <= win_addr;
            if (core_we[win_id]) begin
              state_q   <= WA1;
              mem_awe_q <= 1'b1;
            end else begin
              state_q   <= RD;
            end
          end
        end
        WA1: begin
          state_q   <= WA2;
          mem_din_q <= lat_addr_q;
        end
        WA2: begin
          state_q   <= WR;
          mem_we_q  <= 1'b1;
          mem_din_q <= lat_wdata_q;
        end
        WR: begin
          state_q         <= RESP;
          ack_q[lat_id_q] <= 1'b1;
        end
        RD: begin
          state_q   <= RDW;
          mem_din_q <= lat_addr_q;
        end
        RDW: begin
          state_q         <= RESP;
          rdata_q         <= mem_data_out;
          ack_q[lat_id_q] <= 1'b1;
        end
        RESP: begin
          state_q    <= IDLE;
          mem_addr_q <= '0;
        end
        default: begin
          state_q    <= IDLE;
          mem_addr_q <= '0;
        end
      endcase
    end
  end

  assign busy              = (state_q != IDLE);
  assign core_ack          = ack_q;
  assign core_rdata        = rdata_q;
  assign mem_write_en      = mem_we_q;
  assign mem_addr_write_en = mem_awe_q;
  assign mem_addr          = mem_addr_q;
  assign mem_data_in       = mem_din_q;
endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: behavioural DRAM, blocking core drivers and an
// ack scoreboard fed in expected grant order.
module tb_dram_arbiter;
  localparam int NC = 4;
  localparam int AW = 16;
  localparam int DW = 16;

  logic              clk, rst_n;
  logic [NC-1:0]     core_req, core_we, core_ack;
  logic [NC*AW-1:0]  core_addr;
  logic [NC*DW-1:0]  core_wdata;
  logic [DW-1:0]     core_rdata, mem_data_in, mem_data_out;
  logic [AW-1:0]     mem_addr;
  logic              busy, mem_write_en, mem_addr_write_en;

  dram_arbiter #(.NUM_CORES(NC), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_ack(core_ack), .core_rdata(core_rdata),
    .busy(busy), .mem_write_en(mem_write_en),
    .mem_addr_write_en(mem_addr_write_en), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DRAM model: address latched as addr_write_en falls, write on write_en,
  // data_out registered from the address on data_in.
  logic [DW-1:0] dram [0:255];
  logic [AW-1:0] dram_addr;
  logic          awe_prev;
  logic          pl_en;
  logic [7:0]    pl_a;
  logic [DW-1:0] pl_d;
  always @(posedge clk) begin
    awe_prev <= mem_addr_write_en;
    if (awe_prev && !mem_addr_write_en) dram_addr <= mem_data_in;
    if (mem_write_en) dram[dram_addr[7:0]] <= mem_data_in;
    if (pl_en) dram[pl_a] <= pl_d;
    mem_data_out <= dram[mem_data_in[7:0]];
  end

  typedef struct { int id; bit rd; logic [DW-1:0] data; } exp_t;
  exp_t sb[$];

  always @(negedge clk) begin
    if (rst_n === 1'b1 && core_ack !== '0) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_ack got=%b want=none", core_ack);
      end else begin
        exp_t e;
        logic [NC-1:0] ea;
        e  = sb.pop_front();
        ea = NC'(1) << e.id;
        total++;
        if (core_ack !== ea) begin
          bad++; $display("FAIL ack_id got=%b want=%b", core_ack, ea);
        end
        if (e.rd) begin
          total++;
          if (core_rdata !== e.data) begin
            bad++; $display("FAIL rdata core%0d got=%h want=%h", e.id, core_rdata, e.data);
          end
        end
      end
    end
  end

  // Observations gathered by issue() for single-transaction checks.
  int awe_cnt, we_cnt;
  logic [DW-1:0] awe_data, we_data;
  int ack_t [NC];

  task automatic preload(input logic [7:0] a, input logic [DW-1:0] d);
    pl_a = a; pl_d = d; pl_en = 1'b1;
    @(posedge clk); #1 pl_en = 1'b0;
  endtask

  task automatic issue(input int id, input bit we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, output int lat);
    core_we[id] = we;
    core_addr[id*AW +: AW]  = a;
    core_wdata[id*DW +: DW] = d;
    core_req[id] = 1'b1;
    lat = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (mem_addr_write_en) begin awe_cnt++; awe_data = mem_data_in; end
      if (mem_write_en)      begin we_cnt++;  we_data  = mem_data_in; end
      if (core_ack[id]) begin ack_t[id] = cyc; break; end
      if (lat >= 60) begin
        total++; bad++;
        $display("FAIL timeout core%0d got=no_ack want=ack", id);
        break;
      end
    end
    @(posedge clk); #1 core_req[id] = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; core_req = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; core_req = '0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    total++; if (core_ack !== '0) begin bad++; $display("FAIL rst_ack got=%b want=0", core_ack); end
    total++; if (core_rdata !== '0) begin bad++; $display("FAIL rst_rdata got=%h want=0", core_rdata); end
    total++; if ({mem_write_en, mem_addr_write_en} !== 2'b00) begin
      bad++; $display("FAIL rst_mem_en got=%b want=00", {mem_write_en, mem_addr_write_en}); end
    total++; if (mem_addr !== '0 || mem_data_in !== '0) begin
      bad++; $display("FAIL rst_mem_bus got=%h/%h want=0/0", mem_addr, mem_data_in); end
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    int lat;
    awe_cnt = 0; we_cnt = 0;
    sb.push_back('{0, 1'b0, '0});
    issue(0, 1'b1, 16'd25, 16'h00AB, lat);
    total++; if (lat !== 5) begin bad++; $display("FAIL wr_latency got=%0d want=5", lat); end
    total++; if (awe_cnt !== 1) begin bad++; $display("FAIL wr_awe_cycles got=%0d want=1", awe_cnt); end
    total++; if (awe_data !== 16'd25) begin bad++; $display("FAIL wr_awe_data got=%h want=0019", awe_data); end
    total++; if (we_cnt !== 1) begin bad++; $display("FAIL wr_we_cycles got=%0d want=1", we_cnt); end
    total++; if (we_data !== 16'h00AB) begin bad++; $display("FAIL wr_we_data got=%h want=00ab", we_data); end
    awe_cnt = 0; we_cnt = 0;
    sb.push_back('{0, 1'b1, 16'h00AB});
    issue(0, 1'b0, 16'd25, 16'h0000, lat);
    total++; if (lat !== 4) begin bad++; $display("FAIL rd_latency got=%0d want=4", lat); end
    total++; if (we_cnt + awe_cnt !== 0) begin bad++; $display("FAIL rd_strobes got=%0d want=0", we_cnt + awe_cnt); end
  endtask

  task automatic test_preload_read();
    int lat;
    preload(8'd40, 16'd23);
    we_cnt = 0;
    sb.push_back('{2, 1'b1, 16'd23});
    issue(2, 1'b0, 16'd40, 16'h0000, lat);
    total++; if (we_cnt !== 0) begin bad++; $display("FAIL pre_we_pulse got=%0d want=0", we_cnt); end
  endtask

  task automatic test_contention();
    int l0, l1, l2, l3, l4;
    for (int i = 0; i < NC; i++) preload(8'(100 + i), 16'(16'hC000 + i));
    do_reset();
    for (int i = 0; i < NC; i++) sb.push_back('{i, 1'b1, 16'(16'hC000 + i)});
    sb.push_back('{0, 1'b1, 16'hC000});
    fork
      begin
        issue(0, 1'b0, 16'd100, 16'h0, l0);
        issue(0, 1'b0, 16'd100, 16'h0, l4);
        ack_t[0] = ack_t[0] - ack_t[3];
      end
      issue(1, 1'b0, 16'd101, 16'h0, l1);
      issue(2, 1'b0, 16'd102, 16'h0, l2);
      issue(3, 1'b0, 16'd103, 16'h0, l3);
    join
    total++; if (ack_t[2] - ack_t[1] !== 4) begin bad++; $display("FAIL cont_gap12 got=%0d want=4", ack_t[2] - ack_t[1]); end
    total++; if (ack_t[3] - ack_t[2] !== 4) begin bad++; $display("FAIL cont_gap23 got=%0d want=4", ack_t[3] - ack_t[2]); end
    total++; if (ack_t[0] !== 4) begin bad++; $display("FAIL cont_core0_again got=%0d want=4", ack_t[0]); end
  endtask

  task automatic test_write_read_mix();
    int l1, l3;
    sb.push_back('{1, 1'b0, '0});
    sb.push_back('{3, 1'b1, 16'h1234});
    fork
      issue(1, 1'b1, 16'd41, 16'h1234, l1);
      issue(3, 1'b0, 16'd41, 16'h0000, l3);
    join
    total++; if (l3 - l1 !== 4) begin bad++; $display("FAIL mix_order got=%0d want=4", l3 - l1); end
  endtask

  task automatic test_reset_mid_write();
    int n, lat;
    preload(8'd50, 16'h0777);
    core_we[0] = 1'b1;
    core_addr[0 +: AW] = 16'd50;
    core_wdata[0 +: DW] = 16'h9999;
    core_req[0] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!mem_addr_write_en && n < 20);
    @(negedge clk);
    rst_n = 1'b0; core_req = '0;
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b want=0", busy); end
    total++; if ({mem_write_en, mem_addr_write_en, mem_addr, mem_data_in} !== '0) begin
      bad++; $display("FAIL mid_mem got=%b%b/%h/%h want=0", mem_write_en, mem_addr_write_en, mem_addr, mem_data_in); end
    total++; if (core_ack !== '0) begin bad++; $display("FAIL mid_ack got=%b want=0", core_ack); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    sb.push_back('{0, 1'b1, 16'h0777});
    issue(0, 1'b0, 16'd50, 16'h0000, lat);
  endtask

  task automatic test_idle();
    int errs;
    errs = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy !== 1'b0 || mem_write_en !== 1'b0 || mem_addr_write_en !== 1'b0 || core_ack !== '0)
        errs++;
    end
    total++; if (errs !== 0) begin bad++; $display("FAIL idle_activity got=%0d want=0", errs); end
  endtask

  initial begin
    rst_n = 1'b0; core_req = '0; core_we = '0; core_addr = '0; core_wdata = '0;
    pl_en = 1'b0; pl_a = '0; pl_d = '0;
    test_reset();
    test_write_read();
    test_preload_read();
    test_contention();
    test_write_read_mix();
    test_reset_mid_write();
    test_idle();
    total++;
    if (sb.size() !== 0) begin bad++; $display("FAIL sb_leftover got=%0d want=0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/dram_arbiter.md
Name: dram_arbiter

Overview:
Round-robin arbiter and sequencer between NUM_CORES core memory ports and the single shared DRAM block. Accepts one request at a time and drives the DRAM's two-phase protocol. Writes use an address-latch sequence, then a write strobe. Reads present the address on the DRAM data input and capture the DRAM read output. Returns a one-cycle ack to the granted core, plus read data for reads.

Parameters:
NUM_CORES, 4, number of requesting core ports (2..8)
AW, 16, address width
DW, 16, data width (AW must equal DW; the DRAM data input carries both address and data)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
core_req  input  NUM_CORES  per-core request; held high until that core's ack
core_we  input  NUM_CORES  per-core: 1=write, 0=read; stable while req high
core_addr  input  NUM_CORES*AW  per-core address; core i at bits [i*AW +: AW]
core_wdata  input  NUM_CORES*DW  per-core write data; same packing as core_addr
core_ack  output  NUM_CORES  one-cycle completion pulse to the granted core
core_rdata  output  DW  read data; valid in the ack cycle of a read
busy  output  1  high in every state except IDLE
mem_write_en  output  1  to DRAM write_en
mem_addr_write_en  output  1  to DRAM addr_write_en
mem_addr  output  AW  to DRAM addr; carries the latched address, informational only
mem_data_in  output  DW  to DRAM data_in
mem_data_out  input  DW  from DRAM data_out

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; core_ack=0; core_rdata=0; busy=0.
  - all mem_* outputs=0.
  - rr_ptr=NUM_CORES-1, so core 0 has first priority.
- Mem outputs are decoded from registered state and latched command only; no input-to-output combinational path.
- State encoding and outputs:
  - IDLE: write_en=0, addr_write_en=0, data_in=0.
  - WA1: addr_write_en=1, data_in=lat_addr.
  - WA2: addr_write_en=0, data_in=lat_addr. The DRAM latches its address on the edge leaving WA2.
  - WR: write_en=1, data_in=lat_wdata. The DRAM writes on the edge leaving WR.
  - RD: write_en=0, data_in=lat_addr. The DRAM loads data_out on the edge leaving RD.
  - RDW: write_en=0, data_in=lat_addr. mem_data_out is valid; it is captured into core_rdata on the edge leaving RDW.
  - RESP: core_ack[lat_id]=1, all others 0; mem outputs as IDLE.
- mem_addr=lat_addr in all non-IDLE states, 0 in IDLE.
- Arbitration in IDLE:
  - If any core_req bit is high, winner = first requesting index searching rr_ptr+1, rr_ptr+2, ... modulo NUM_CORES.
  - On that edge: latch lat_id, lat_addr, lat_wdata, lat_we from the winner; set rr_ptr=winner.
  - Next state: WA1 if core_we[winner] is 1, else RD.
  - No request: stay in IDLE.
- Transitions: WA1->WA2->WR->RESP; RD->RDW->RESP; RESP->IDLE, all unconditional.
- Latency from the grant edge:
  - Write: ack high in the 4th cycle (WA1, WA2, WR, RESP).
  - Read: ack high in the 3rd cycle (RD, RDW, RESP).
  - Minimum issue interval: 5 cycles per write, 4 per read, because of the IDLE cycle.
- Handshake:
  - A core holds req, we, addr and wdata constant until it sees ack.
  - It deasserts req on the edge ending its ack cycle, so it is low when the arbiter next samples in IDLE.
  - Inputs are sampled only in IDLE. Changes during a transaction have no effect on it.
- core_rdata holds its last captured value until the next read capture; writes do not alter it.
- Simultaneous requests: exactly one grant per IDLE cycle. The rotating pointer guarantees each requester is served within NUM_CORES transactions.
- Dropping req before ack is a protocol violation. The latched transaction still completes and ack still pulses.
- Reset mid-transaction: the transaction is abandoned and all outputs return to reset values the next cycle. If reset is sampled before the edge leaving WR, the DRAM is not written.

Test Plan:
- Single write then read, core 0: write addr=25, wdata=0x00AB -> mem_addr_write_en high 1 cycle with data_in=25, write_en high 1 cycle with data_in=0x00AB, ack[0] 4 cycles after grant. Then read addr=25 -> core_rdata=0x00AB with ack[0] 3 cycles after grant.
- Preloaded read: core 2 reads addr=40 with DRAM preloaded 23 -> core_rdata=23, ack=4'b0100, no mem_write_en pulse.
- Contention: cores 0-3 all request reads at once from reset -> grants in order 0,1,2,3, acks 4 cycles apart. Core 0 re-requests after its ack -> next grant goes to core 1, not core 0.
- Write/read mix: core 1 writes 0x1234 to addr=41 while core 3 requests a read of addr=41 -> core 1 is served first; core 3 then reads 0x1234.
- Reset mid-write: rst_n low during WA2 -> next cycle busy=0, all mem_* outputs=0, no ack. A subsequent read of that address returns the old value.
- Idle stability: no requests for 20 cycles -> busy=0, mem_write_en and mem_addr_write_en stay 0, core_ack stays 0.
